// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode map, FSM states and
// the legal-opcode check.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_LSH = 4'b0000;
    localparam logic [3:0] OP_RSH = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_GEQ = 4'b1000;
    localparam logic [3:0] OP_EQ  = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b1011;
    localparam logic [3:0] OP_NEQ = 4'b1101;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            OP_LSH, OP_RSH, OP_AND, OP_OR,
            OP_GEQ, OP_EQ, OP_NEG, OP_ADD, OP_NEQ: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the port that was not granted last
// wins. Output is one-hot or zero, and zero whenever en is low.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = en & req[0] & (~req[1] | lastGrant);
        grant[1] = en & req[1] & (~req[0] | ~lastGrant);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// one-cycle ALU issue, registered result held on a per-port response channel.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         req_valid0,
    input  logic [3:0]   req_op0,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    output logic         req_ready0,
    input  logic         req_valid1,
    input  logic [3:0]   req_op1,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic         req_ready1,
    output logic         rsp_valid0,
    input  logic         rsp_ready0,
    output logic         rsp_valid1,
    input  logic         rsp_ready1,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero
);

    arb_state_t   state;
    logic         lastGrant;
    logic         owner;
    logic [3:0]   opR;
    logic [W-1:0] aR;
    logic [W-1:0] bR;
    logic [1:0]   grant;
    logic         grantEn;
    logic [3:0]   selOp;
    logic [W-1:0] selA;
    logic [W-1:0] selB;
    logic         ownerReady;

    // Grants are suppressed while Reset is high so a requester never sees a
    // handshake that the reset is about to throw away.
    assign grantEn = (state == ARB_IDLE) && !Reset;

    rr_arbiter2 u_rr (
        .req       ({req_valid1, req_valid0}),
        .lastGrant (lastGrant),
        .en        (grantEn),
        .grant     (grant)
    );

    assign req_ready0 = grant[0];
    assign req_ready1 = grant[1];

    assign selOp = grant[1] ? req_op1 : req_op0;
    assign selA  = grant[1] ? req_a1  : req_a0;
    assign selB  = grant[1] ? req_b1  : req_b0;

    assign rsp_valid0 = (state == ARB_RESP) && !owner;
    assign rsp_valid1 = (state == ARB_RESP) &&  owner;
    assign ownerReady = owner ? rsp_ready1 : rsp_ready0;

    assign alu_op = (state == ARB_ISSUE) ? opR : 4'b0000;
    assign alu_a  = (state == ARB_ISSUE) ? aR  : '0;
    assign alu_b  = (state == ARB_ISSUE) ? bR  : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ARB_IDLE;
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            opR       <= 4'b0000;
            aR        <= '0;
            bR        <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|grant) begin
                        owner     <= grant[1];
                        lastGrant <= grant[1];
                        opR       <= selOp;
                        aR        <= selA;
                        bR        <= selB;
                        if (is_legal_op(selOp)) begin
                            state <= ARB_ISSUE;
                        end else begin
                            // Illegal ops skip the ALU and answer with an error.
                            state    <= ARB_RESP;
                            rsp_data <= '0;
                            rsp_zero <= 1'b0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ARB_ISSUE: begin
                    rsp_data <= alu_out;
                    rsp_zero <= alu_zero;
                    rsp_err  <= 1'b0;
                    state    <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (ownerReady) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: port 0 (core datapath) and port 1 (auxiliary unit, e.g. a checksum or loop helper).
- Each request carries an opcode and two operands over a valid/ready handshake. The block grants round-robin, drives the ALU for one cycle, registers the result, and returns it on a per-port valid/ready response channel.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

Parameters:
- W, 8, operand/result width in bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid0  in  1  port 0 request valid.
- req_op0  in  4  port 0 opcode (shared instruction-map encoding).
- req_a0  in  W  port 0 operand A.
- req_b0  in  W  port 0 operand B.
- req_ready0  out  1  port 0 request accepted this cycle.
- req_valid1, req_op1, req_a1, req_b1, req_ready1  as for port 0, for port 1.
- rsp_valid0  out  1  port 0 response valid.
- rsp_ready0  in  1  port 0 consumes response.
- rsp_valid1  out  1  port 1 response valid.
- rsp_ready1  in  1  port 1 consumes response.
- rsp_data  out  W  result; shared by both ports, meaningful only with the owner's rsp_valid.
- rsp_zero  out  1  registered ALU zero flag.
- rsp_err  out  1  1 = opcode was illegal, result suppressed.
- alu_op  out  4  opcode to ALU.
- alu_a  out  W  operand A to ALU.
- alu_b  out  W  operand B to ALU.
- alu_out  in  W  ALU result (combinational).
- alu_zero  in  1  ALU zero flag.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- Reset (synchronous): state=IDLE, last_grant=1 (so port 0 wins the first contention).
  - Cleared: owner, op_r, a_r, b_r, rsp_data, rsp_zero, rsp_err.
  - All req_ready/rsp_valid outputs 0; alu_op/alu_a/alu_b = 0.
- IDLE:
  - Grant = port with req_valid set. If both are set, grant the port != last_grant.
  - req_readyN = 1 combinationally, for the granted port only; at most one req_ready is high per cycle.
  - On handshake: capture op/a/b into op_r/a_r/b_r, set owner=N, last_grant=N.
  - Next state: ISSUE if the opcode is legal; otherwise RESP with rsp_err=1, rsp_data=0, rsp_zero=0.
  - No request: stay in IDLE.
- Legal opcodes: 0000 LSH, 0001 RSH, 0010 AND, 0011 OR, 1000 GEQ, 1001 EQ, 1010 NEG, 1011 ADD, 1101 NEQ. All other 4-bit values are illegal.
- ISSUE (exactly 1 cycle):
  - alu_op/alu_a/alu_b = op_r/a_r/b_r; these outputs are 0 in every other state.
  - At the clock edge: rsp_data <= alu_out, rsp_zero <= alu_zero, rsp_err <= 0; next state RESP.
- RESP:
  - rsp_valid[owner]=1; the other port's rsp_valid=0.
  - rsp_data/zero/err are held stable while waiting.
  - When rsp_ready[owner]=1: return to IDLE. No new request is accepted in the same cycle.
  - Back-pressure is unbounded; the other port stalls with req_ready=0.
- Latency:
  - Legal op: handshake in cycle t, ALU driven in t+1, rsp_valid from t+2.
  - Illegal op: rsp_valid from t+1.
  - Maximum throughput: one op per 3 cycles.
- Requester rule: a requester holds valid/op/a/b stable until ready. The arbiter never drops a pending valid.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
- Reset mid-operation (in ISSUE or RESP): the in-flight op is discarded with no response, and all reset values apply on the next cycle.
- Simultaneous reset and handshake: reset wins; nothing is captured.
- Width: no arithmetic inside this block; rsp_data is alu_out truncated/extended exactly as W.

Decomposition:
- Shared package additions:
  - typedef enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t.
  - Function is_legal_op(logic[3:0]) returning 1 for the nine opcode constants already in the package.
- Sub-module rr_arbiter2 (req[1:0], last_grant, en -> grant[1:0], one-hot or zero).
- FSM, operand registers and response registers stay in alu_arbiter.

Test Plan:
- Single request: port 0, ADD, a=8'h05, b=8'h03, rsp_ready0=1.
  - -> req_ready0 in cycle t; alu_op=1011 in t+1; rsp_valid0=1, rsp_data=8'h08, rsp_zero=0, rsp_err=0 in t+2; rsp_valid1 stays 0.
- Contention: both ports valid continuously; port 0 AND 8'hF0&8'h0F, port 1 OR 8'hF0|8'h0F.
  - -> first grant port 0 with rsp_data=8'h00, rsp_zero=1.
  - -> then port 1 with rsp_data=8'hFF.
  - -> grant order 0,1,0,1 over 4 ops.
- Illegal op: port 1, op=4'b0100.
  - -> alu_op stays 0.
  - -> rsp_valid1 at t+1 with rsp_err=1, rsp_data=8'h00.
- Back-pressure: port 0 EQ 8'h22,8'h22; rsp_ready0 held 0 for 5 cycles while port 1 is valid.
  - -> rsp_valid0 and rsp_data stable for all 5 cycles; req_ready1=0 throughout.
  - -> port 1 granted the cycle after rsp_ready0 rises.
- Reset mid-operation: assert Reset for 1 cycle during ISSUE.
  - -> no rsp_valid for that op; all outputs at reset values.
  - -> next contention grants port 0 first.
